// File: rtl/pc_fetch_pkg.sv
// Shared types and default parameters for the program-counter fetch unit.
// The optional stall counter is built only when PCFU_STATS_EN is defined.
package pc_fetch_pkg;

  localparam int          PCFU_ADDR_W   = 16;
  localparam int          PCFU_DATA_W   = 16;
  localparam logic [15:0] PCFU_RESET_PC = 16'h0000;
  localparam int          PCFU_PC_INC   = 2;
  localparam int          PCFU_STALL_W  = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-PC selector: redirect target (halfword aligned) beats sequential
// increment, which beats holding the current PC.
module pc_next_sel #(
  parameter int ADDR_W = 16,
  parameter int PC_INC = 2
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              fetch_done_i,
  output logic [ADDR_W-1:0] pc_next_o
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  logic unused_target_lsb;
  assign unused_target_lsb = br_target_i[0];

  always_comb begin
    pc_next_o = pc_i;
    if (br_taken_i) begin
      pc_next_o = {br_target_i[ADDR_W-1:1], 1'b0};
    end else if (fetch_done_i) begin
      // Wraps naturally modulo 2^ADDR_W (FFFE -> 0000).
      pc_next_o = pc_i + INC;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the PC, fetches words over REQ/ACK and hands them to decode over valid/ready.
// Define PCFU_STATS_EN to add the saturating stall_cnt_o counter.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int                DATA_W   = PCFU_DATA_W,
  parameter int                ADDR_W   = PCFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PCFU_RESET_PC),
  parameter int                PC_INC   = PCFU_PC_INC
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_out_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic [1:0]        state_o
`ifdef PCFU_STATS_EN
  ,
  output logic [PCFU_STALL_W-1:0] stall_cnt_o
`endif
);

  // Handshakes: a memory read completes on a cycle with mem_req_o && mem_ack_i;
  // an instruction transfers on a cycle with inst_valid_o && inst_ready_i. Once
  // raised, mem_req_o/mem_addr_o hold until the ack, even across a redirect.

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_out_q, inst_out_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              fetch_done;

  assign fetch_done = (state_q == FETCH) && mem_req_q && mem_ack_i && !br_taken_i;

  pc_next_sel #(
    .ADDR_W (ADDR_W),
    .PC_INC (PC_INC)
  ) u_pc_next_sel (
    .pc_i         (pc_q),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .fetch_done_i (fetch_done),
    .pc_next_o    (pc_d)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    case (state_q)
      FETCH: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_d;
        end else if (mem_ack_i) begin
          // A redirect in the ack cycle discards the word and leaves REQ low one cycle.
          mem_req_d = 1'b0;
          if (!br_taken_i) begin
            inst_out_d   = mem_rdata_i;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (br_taken_i) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (br_taken_i || inst_ready_i) begin
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_out_o   = inst_out_q;
  assign inst_pc_o    = inst_pc_q;
  assign state_o      = state_q;

`ifdef PCFU_STATS_EN
  logic [PCFU_STALL_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (mem_req_q && !mem_ack_i && (stall_cnt_q != {PCFU_STALL_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, backpressure, redirects,
// reset behaviour, PC wrap, and (with PCFU_STATS_EN) the stall counter.
module tb_pc_fetch_unit;
  import pc_fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack_i;
  logic [15:0] mem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [15:0] inst_out_o;
  logic [15:0] inst_pc_o;
  logic        br_taken_i;
  logic [15:0] br_target_i;
  logic [1:0]  state_o;

  logic        mem_req2, mem_ack2, inst_valid2, inst_ready2, br_taken2;
  logic [15:0] mem_addr2, mem_rdata2, inst_out2, inst_pc2, br_target2;
  logic [1:0]  state2;
`ifdef PCFU_STATS_EN
  logic [15:0] stall_cnt, stall_cnt2;
`endif

  int total = 0;
  int bad   = 0;
  int ack_delay = 1;
  bit mem_hold  = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  pc_fetch_unit dut (
    .clk_i (clk_i), .rst_n_i (rst_n_i),
    .mem_req_o (mem_req_o), .mem_addr_o (mem_addr_o),
    .mem_ack_i (mem_ack_i), .mem_rdata_i (mem_rdata_i),
    .inst_valid_o (inst_valid_o), .inst_ready_i (inst_ready_i),
    .inst_out_o (inst_out_o), .inst_pc_o (inst_pc_o),
    .br_taken_i (br_taken_i), .br_target_i (br_target_i),
    .state_o (state_o)
`ifdef PCFU_STATS_EN
    , .stall_cnt_o (stall_cnt)
`endif
  );

  pc_fetch_unit #(.RESET_PC (16'hFFFE)) dut_wrap (
    .clk_i (clk_i), .rst_n_i (rst_n_i),
    .mem_req_o (mem_req2), .mem_addr_o (mem_addr2),
    .mem_ack_i (mem_ack2), .mem_rdata_i (mem_rdata2),
    .inst_valid_o (inst_valid2), .inst_ready_i (inst_ready2),
    .inst_out_o (inst_out2), .inst_pc_o (inst_pc2),
    .br_taken_i (br_taken2), .br_target_i (br_target2),
    .state_o (state2)
`ifdef PCFU_STATS_EN
    , .stall_cnt_o (stall_cnt2)
`endif
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory responders: main DUT acks after ack_delay stall cycles, wrap DUT acks at once.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    mem_ack2 = 1'b0; mem_rdata2 = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack2   = rst_n_i && mem_req2;
      mem_rdata2 = mem_word(mem_addr2);
      if (!rst_n_i) begin
        mem_ack_i = 1'b0; cnt = 0;
      end else begin
        if (mem_ack_i) begin mem_ack_i = 1'b0; cnt = 0; end
        if (mem_req_o && !mem_hold) begin
          cnt++;
          if (cnt > ack_delay) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem_word(mem_addr_o);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n_i = 1'b0; br_taken_i = 1'b0; br_target_i = '0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk_i);
      if (mem_req_o) got = 1'b1;
    end
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk_i);
      if (inst_valid_o) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; br_taken_i = 1'b0; br_target_i = '0;
    inst_ready_i = 1'b1; inst_ready2 = 1'b1; br_taken2 = 1'b0; br_target2 = '0;
    repeat (2) @(negedge clk_i);
    total++;
    if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_out_o !== 16'h0 ||
        inst_pc_o !== 16'h0 || state_o !== FETCH) begin
      bad++;
      $display("FAIL reset_state: req=%b valid=%b out=%h pc=%h st=%0d required 0 0 0000 0000 0",
               mem_req_o, inst_valid_o, inst_out_o, inst_pc_o, state_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h0000) begin
      bad++;
      $display("FAIL reset_first_req: req=%b addr=%h required 1 0000", mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_sequential();
    bit got;
    logic [15:0] exp_pc;
    do_reset();
    ack_delay = 1; inst_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_req(got);
      total++;
      if (!got || mem_addr_o !== 16'(2 * i)) begin
        bad++;
        $display("FAIL seq_addr%0d: got=%b addr=%h required %h", i, got, mem_addr_o, 16'(2 * i));
      end
      exp_q.push_back(16'(2 * i));
      wait_valid(got);
      exp_pc = exp_q.pop_front();
      total++;
      if (!got || inst_pc_o !== exp_pc || inst_out_o !== mem_word(exp_pc)) begin
        bad++;
        $display("FAIL seq_inst%0d: got=%b pc=%h out=%h required %h %h",
                 i, got, inst_pc_o, inst_out_o, exp_pc, mem_word(exp_pc));
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    do_reset();
    ack_delay = 1; inst_ready_i = 1'b0;
    wait_valid(got);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      total++;
      if (!got || inst_valid_o !== 1'b1 || inst_out_o !== mem_word(16'h0000) || mem_req_o !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: valid=%b out=%h req=%b required 1 %h 0",
                 i, inst_valid_o, inst_out_o, mem_req_o, mem_word(16'h0000));
      end
    end
    inst_ready_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (inst_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: valid=%b required 0", inst_valid_o);
    end
  endtask

  task automatic test_branch_drain();
    bit got;
    do_reset();
    ack_delay = 3; inst_ready_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk_i);
      if (mem_req_o && mem_addr_o == 16'h0004) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL drain_setup: no request at 0004 seen, required one"); end
    br_taken_i = 1'b1; br_target_i = 16'h0101;
    @(negedge clk_i);
    br_taken_i = 1'b0;
    for (int k = 0; k < 20 && mem_req_o; k++) begin
      total++;
      if (mem_addr_o !== 16'h0004 || inst_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL drain_hold: addr=%h valid=%b required 0004 0", mem_addr_o, inst_valid_o);
      end
      @(negedge clk_i);
    end
    wait_req(got);
    total++;
    if (!got || mem_addr_o !== 16'h0100) begin
      bad++;
      $display("FAIL drain_redirect_addr: got=%b addr=%h required 0100", got, mem_addr_o);
    end
    wait_valid(got);
    total++;
    if (!got || inst_pc_o !== 16'h0100 || inst_out_o !== mem_word(16'h0100)) begin
      bad++;
      $display("FAIL drain_redirect_inst: pc=%h out=%h required 0100 %h",
               inst_pc_o, inst_out_o, mem_word(16'h0100));
    end
  endtask

  task automatic test_branch_hold();
    bit got;
    do_reset();
    ack_delay = 1; inst_ready_i = 1'b0;
    wait_valid(got);
    br_taken_i = 1'b1; br_target_i = 16'h0041;
    @(negedge clk_i);
    br_taken_i = 1'b0; inst_ready_i = 1'b1;
    total++;
    if (!got || inst_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_branch_valid: valid=%b required 0", inst_valid_o);
    end
    wait_req(got);
    total++;
    if (!got || mem_addr_o !== 16'h0040) begin
      bad++;
      $display("FAIL hold_branch_addr: addr=%h required 0040", mem_addr_o);
    end
  endtask

  task automatic test_branch_with_ack();
    bit got;
    do_reset();
    ack_delay = 0; inst_ready_i = 1'b1;
    wait_req(got);
    br_taken_i = 1'b1; br_target_i = 16'h0080;
    @(negedge clk_i);
    br_taken_i = 1'b0;
    total++;
    if (!got || mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL ackbr_drop: req=%b valid=%b required 0 0", mem_req_o, inst_valid_o);
    end
    @(negedge clk_i);
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h0080) begin
      bad++;
      $display("FAIL ackbr_addr: req=%b addr=%h required 1 0080", mem_req_o, mem_addr_o);
    end
    wait_valid(got);
    total++;
    if (!got || inst_pc_o !== 16'h0080) begin
      bad++;
      $display("FAIL ackbr_inst: pc=%h required 0080", inst_pc_o);
    end
  endtask

  task automatic test_wrap();
    bit got;
    do_reset();
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk_i); if (mem_req2) got = 1'b1; end
    total++;
    if (!got || mem_addr2 !== 16'hFFFE) begin
      bad++;
      $display("FAIL wrap_first: addr=%h required FFFE", mem_addr2);
    end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk_i); if (inst_valid2) got = 1'b1; end
    total++;
    if (!got || inst_pc2 !== 16'hFFFE || inst_out2 !== mem_word(16'hFFFE)) begin
      bad++;
      $display("FAIL wrap_inst: pc=%h out=%h required FFFE %h", inst_pc2, inst_out2, mem_word(16'hFFFE));
    end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk_i); if (mem_req2) got = 1'b1; end
    total++;
    if (!got || mem_addr2 !== 16'h0000 || $isunknown(mem_addr2)) begin
      bad++;
      $display("FAIL wrap_second: addr=%h required 0000", mem_addr2);
    end
  endtask

  task automatic test_async_reset();
    bit got;
    do_reset();
    ack_delay = 1; inst_ready_i = 1'b0;
    wait_valid(got);
    #2 rst_n_i = 1'b0;
    #1;
    total++;
    if (!got || inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: valid=%b req=%b required 0 0", inst_valid_o, mem_req_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1; inst_ready_i = 1'b1;
    wait_req(got);
    total++;
    if (!got || mem_addr_o !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset_pc: addr=%h required 0000", mem_addr_o);
    end
  endtask

`ifdef PCFU_STATS_EN
  task automatic test_stall_cnt();
    bit got;
    do_reset();
    total++;
    if (stall_cnt !== 16'h0) begin bad++; $display("FAIL stall_reset: cnt=%h required 0000", stall_cnt); end
    ack_delay = 3; inst_ready_i = 1'b1;
    wait_valid(got);
    @(negedge clk_i);
    wait_valid(got);
    total++;
    if (!got || stall_cnt !== 16'd6) begin
      bad++;
      $display("FAIL stall_six: cnt=%0d required 6", stall_cnt);
    end
    mem_hold = 1'b1;
    repeat (70000) @(negedge clk_i);
    total++;
    if (stall_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL stall_saturate: cnt=%h required FFFF", stall_cnt);
    end
    mem_hold = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_drain();
    test_branch_hold();
    test_branch_with_ack();
    test_wrap();
    test_async_reset();
`ifdef PCFU_STATS_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
